// File: rtl/rambus_arbiter.sv
// Purpose : two-master / one-slave RamBus arbiter with round-robin fairness.
// Latency : 4 clk from Sel rising to Ack with a zero-wait slave; +1 per slave wait cycle.
// Backpressure: the non-granted master sees Ack=0 (APB wait states) until it is served.
//
// Ports:
//   clk, nRst                  fabric clock, asynchronous active-low reset
//   Sel/Latch/WrnRd/Address/DataIn{0,1}  APB-style master request side
//   Ack/Err/DataOut{0,1}       registered master response (granted master only)
//   SlvSel/SlvLatch/SlvWrnRd/SlvAddress/SlvDataIn  registered slave request side
//   SlvAck/SlvDataOut          slave response
//   Granted                    one-hot current grant for debug pins
// Optional feature: define RAMBUS_ARB_TIMEOUT_EN to bound the ACCESS phase; an
// expired access completes with Err=1 and DataOut=ERR_DATA. Without it ACCESS
// waits indefinitely for SlvAck and Err0/Err1 are always 0.
module rambus_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
`ifdef RAMBUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
`endif
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              Sel0,
    input  logic              Sel1,
    input  logic              Latch0,
    input  logic              Latch1,
    input  logic              WrnRd0,
    input  logic              WrnRd1,
    input  logic [ADDR_W-1:0] Address0,
    input  logic [ADDR_W-1:0] Address1,
    input  logic [DATA_W-1:0] DataIn0,
    input  logic [DATA_W-1:0] DataIn1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Err0,
    output logic              Err1,
    output logic [DATA_W-1:0] DataOut0,
    output logic [DATA_W-1:0] DataOut1,
    output logic              SlvSel,
    output logic              SlvLatch,
    output logic              SlvWrnRd,
    output logic [ADDR_W-1:0] SlvAddress,
    output logic [DATA_W-1:0] SlvDataIn,
    input  logic              SlvAck,
    input  logic [DATA_W-1:0] SlvDataOut,
    output logic [1:0]        Granted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic              gnt;      // index of the granted master
    logic              last;     // index of the last served master
    logic              aborted;  // granted master dropped Sel during SETUP/ACCESS
    logic [DATA_W-1:0] rdat;     // completion data waiting for DONE
    logic              err_cap;  // completion error waiting for DONE

    logic              req0;
    logic              req1;
    logic              g_sel;
    logic              g_latch;
    logic              timeout;

    logic              grant;
    logic              pick;
    logic              cap_ok;
    logic              finish;
    logic              fire;

    // A master whose Ack is high this cycle is still holding Sel from the
    // transfer that just completed; it must not be treated as a new request.
    assign req0    = Sel0 && !Ack0;
    assign req1    = Sel1 && !Ack1;
    assign g_sel   = gnt ? Sel1   : Sel0;
    assign g_latch = gnt ? Latch1 : Latch0;

`ifdef RAMBUS_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    // Counter holds the number of ACCESS cycles already elapsed, so the
    // TIMEOUT_CYC-th ACCESS cycle is the one where it equals TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            to_cnt <= '0;
        end else if (grant) begin
            to_cnt <= '0;
        end else if (state == ACCESS) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == ACCESS) && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        pick       = 1'b0;
        cap_ok     = 1'b0;
        finish     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    // On a tie the master that was not served last wins.
                    pick       = (req0 && req1) ? !last : req1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // SlvAck wins over a coincident timeout.
                if (SlvAck) begin
                    cap_ok     = 1'b1;
                    next_state = DONE;
                end else if (timeout) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (aborted || !g_sel) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else if (g_latch) begin
                    finish     = 1'b1;
                    fire       = 1'b1;
                    next_state = IDLE;
                end
                // Sel high but Latch still low: wait in DONE.
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            gnt        <= 1'b0;
            last       <= 1'b1;
            aborted    <= 1'b0;
            rdat       <= '0;
            err_cap    <= 1'b0;
            Granted    <= 2'b00;
            SlvSel     <= 1'b0;
            SlvLatch   <= 1'b0;
            SlvWrnRd   <= 1'b0;
            SlvAddress <= '0;
            SlvDataIn  <= '0;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Err0       <= 1'b0;
            Err1       <= 1'b0;
            DataOut0   <= '0;
            DataOut1   <= '0;
        end else begin
            // Ack/Err are single-cycle pulses.
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            Err0 <= 1'b0;
            Err1 <= 1'b0;

            if (grant) begin
                gnt        <= pick;
                Granted    <= pick ? 2'b10 : 2'b01;
                SlvSel     <= 1'b1;
                SlvWrnRd   <= pick ? WrnRd1   : WrnRd0;
                SlvAddress <= pick ? Address1 : Address0;
                SlvDataIn  <= pick ? DataIn1  : DataIn0;
                aborted    <= 1'b0;
            end else if (((state == SETUP) || (state == ACCESS)) && !g_sel) begin
                // Remembered so that a master re-raising Sel before DONE is
                // not acked with the result of the abandoned transfer.
                aborted <= 1'b1;
            end

            if (state == SETUP) begin
                SlvLatch <= 1'b1;
            end

            if (cap_ok) begin
                SlvSel   <= 1'b0;
                SlvLatch <= 1'b0;
                rdat     <= SlvWrnRd ? '0 : SlvDataOut;
                err_cap  <= 1'b0;
            end
`ifdef RAMBUS_ARB_TIMEOUT_EN
            else if (timeout) begin
                SlvSel   <= 1'b0;
                SlvLatch <= 1'b0;
                rdat     <= ERR_DATA;
                err_cap  <= 1'b1;
            end
`endif

            if (finish) begin
                Granted <= 2'b00;
                last    <= gnt;
                if (fire) begin
                    if (gnt) begin
                        Ack1     <= 1'b1;
                        DataOut1 <= rdat;
                        Err1     <= err_cap;
                    end else begin
                        Ack0     <= 1'b1;
                        DataOut0 <= rdat;
                        Err0     <= err_cap;
                    end
                end
            end
        end
    end

endmodule
